snake_sequencer: RTL and testbench
==================================

SNAKE_SEQUENCER -- requirements
Module: snake_sequencer

Interface
REQ-001 Parameter NSEG, default 5, number of body segments held.
REQ-002 Parameter STEP, default 16, pixels moved per tick.
REQ-003 Parameter X_MAX, default 608, right wall x coordinate; parameter Y_MAX, default 448, bottom wall y coordinate; left and top walls SHALL be coordinate 0.
REQ-004 Parameter X0 / Y0, defaults 304 / 224, start head position.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins or restarts a game.
REQ-008 tick  in  1  one-cycle move request (frame update).
REQ-009 dir  in  2  requested direction: 0 up, 1 right, 2 down, 3 left.
REQ-010 obEnd  in  1  external obstacle hit; level, sampled only in CHECK.
REQ-011 head  out  20  current head, [19:10] x, [9:0] y.
REQ-012 body  out  20*NSEG  segments; segment k at [20k+19:20k], segment 0 nearest head.
REQ-013 busy  out  1  high whenever state is not IDLE, READY or OVER.
REQ-014 moved  out  1  one-cycle pulse when a move commits.
REQ-015 isOver  out  1  game-over flag, held until start.

Function
REQ-016 States SHALL be IDLE, READY, MOVE, CHECK, COMMIT, OVER.
REQ-017 IDLE: on start go to READY, loading head=(X0,Y0) and segment k=(X0-STEP*(k+1), Y0).
REQ-018 READY: on tick latch dir into cur_dir unless it is the exact reverse of cur_dir (reverse ignored), go to MOVE; tick is ignored in every other state.
REQ-019 MOVE: compute next head by +/-STEP on one axis in 10-bit unsigned arithmetic (wrap allowed), clear seg index, go to CHECK; one cycle.
REQ-020 CHECK: compare next head to wall bounds (x==0, x>=X_MAX, y==0, y>=Y_MAX) and obEnd on the first CHECK cycle; compare against one segment per cycle, index 0..NSEG-2 (tail segment excluded, since it vacates).
REQ-021 Any hit SHALL go to OVER next cycle, aborting remaining compares; no hit after index NSEG-2 goes to COMMIT.
REQ-022 COMMIT: body shifts one segment toward tail (segment 0 := old head), head := next head, moved pulses, return to READY.
REQ-023 Tick-to-moved latency with no hit SHALL be exactly NSEG+2 cycles.
REQ-024 OVER: isOver=1, head/body frozen; start returns to READY with fresh positions as in REQ-017.
REQ-025 start in READY, MOVE, CHECK or COMMIT SHALL abort the move and reinitialise as in REQ-017, isOver cleared; start has priority over tick.
REQ-026 cur_dir SHALL initialise to right (1) on every start.

Reset
REQ-027 rst_n low SHALL force IDLE, head=0, body=0, cur_dir=1, isOver=0, moved=0, busy=0, seg index=0, asynchronously.
REQ-028 Reset release SHALL take effect on the next clk edge; no move until start.

Structure
REQ-029 Shared package snake_pkg SHALL hold state encoding, direction codes, segment width (20) and wall defaults.
REQ-030 One sub-module seg_compare (20-bit equality plus wall check, combinational) is natural; the FSM stays in snake_sequencer.

Verification
REQ-031 Reset then start, tick with dir=1 -> moved after 7 cycles, head=(320,224), segment0=(304,224).
REQ-032 From start, tick with dir=3 (reverse) -> ignored, head=(320,224).
REQ-033 Head at x=16, dir=3, tick -> isOver=1 on cycle after first CHECK, head stays at x=16.
REQ-034 Loop body so next head equals segment 2 -> OVER entered after third compare, moved never pulses.
REQ-035 obEnd=1 during CHECK -> isOver=1; start -> READY, isOver=0, head=(304,224).
REQ-036 rst_n asserted mid-CHECK -> outputs zero immediately, state IDLE, tick ignored until start.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types, direction codes and default geometry for the snake sequencer.
// Coordinates are 10-bit unsigned; a segment packs x in [19:10] and y in [9:0].
package snake_pkg;

  localparam int SEG_W     = 20;
  localparam int COORD_W   = 10;
  localparam int NSEG_DEF  = 5;
  localparam int STEP_DEF  = 16;
  localparam int X_MAX_DEF = 608;
  localparam int Y_MAX_DEF = 448;
  localparam int X0_DEF    = 304;
  localparam int Y0_DEF    = 224;

  typedef logic [COORD_W-1:0] coordT;
  typedef logic [SEG_W-1:0]   segT;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_MOVE   = 3'd2,
    S_CHECK  = 3'd3,
    S_COMMIT = 3'd4,
    S_OVER   = 3'd5
  } stateT;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dirT;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic isReverse(input dirT a, input dirT b);
    return (a ^ b) == 2'd2;
  endfunction

  function automatic segT packSeg(input coordT x, input coordT y);
    return {x, y};
  endfunction

  function automatic segT stepHead(input segT h, input dirT d, input coordT step);
    coordT x;
    coordT y;
    x = h[SEG_W-1:COORD_W];
    y = h[COORD_W-1:0];
    case (d)
      DIR_UP:    y = y - step;
      DIR_RIGHT: x = x + step;
      DIR_DOWN:  y = y + step;
      default:   x = x - step;
    endcase
    return {x, y};
  endfunction

endpackage

// File: rtl/seg_compare.sv
// Combinational collision test of a candidate head against one body segment
// and against the four walls of the playfield.
module seg_compare
  import snake_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic [SEG_W-1:0] candidate,
  input  logic [SEG_W-1:0] segment,
  output logic             segHit,
  output logic             wallHit
);

  coordT candX;
  coordT candY;

  assign candX  = candidate[SEG_W-1:COORD_W];
  assign candY  = candidate[COORD_W-1:0];
  assign segHit = (candidate == segment);

  assign wallHit = (candX == '0) || (candX >= coordT'(X_MAX)) ||
                   (candY == '0) || (candY >= coordT'(Y_MAX));

endmodule

// File: rtl/snake_sequencer.sv
// Snake game move sequencer: turns a tick into a checked one-step move,
// scanning the body one segment per cycle before committing the new head.
module snake_sequencer
  import snake_pkg::*;
#(
  parameter int NSEG  = NSEG_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int X0    = X0_DEF,
  parameter int Y0    = Y0_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  tick,
  input  logic [1:0]            dir,
  input  logic                  obEnd,
  output logic [SEG_W-1:0]      head,
  output logic [SEG_W*NSEG-1:0] body,
  output logic                  busy,
  output logic                  moved,
  output logic                  isOver
);

  localparam int IDX_W = (NSEG > 2) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 2);

  function automatic logic [SEG_W*NSEG-1:0] startBody();
    logic [SEG_W*NSEG-1:0] b;
    b = '0;
    for (int k = 0; k < NSEG; k++) begin
      b[k*SEG_W +: SEG_W] = packSeg(coordT'(X0 - STEP * (k + 1)), coordT'(Y0));
    end
    return b;
  endfunction

  localparam segT                   START_HEAD = {coordT'(X0), coordT'(Y0)};
  localparam logic [SEG_W*NSEG-1:0] START_BODY = startBody();

  stateT           state;
  dirT             curDir;
  segT             nextHead;
  logic [IDX_W-1:0] segIdx;

  segT  curSeg;
  logic segHit;
  logic wallHit;
  logic hit;

  assign curSeg = body[segIdx*SEG_W +: SEG_W];

  seg_compare #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) uCompare (
    .candidate(nextHead),
    .segment  (curSeg),
    .segHit   (segHit),
    .wallHit  (wallHit)
  );

  // Walls and the obstacle input only matter on the first compare cycle.
  assign hit = segHit || ((segIdx == '0) && (wallHit || obEnd));

  // Tail segment is never compared: it vacates on the same commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      curDir   <= DIR_RIGHT;
      head     <= '0;
      body     <= '0;
      nextHead <= '0;
      segIdx   <= '0;
      busy     <= 1'b0;
      moved    <= 1'b0;
      isOver   <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (start) begin
        state  <= S_READY;
        head   <= START_HEAD;
        body   <= START_BODY;
        curDir <= DIR_RIGHT;
        segIdx <= '0;
        busy   <= 1'b0;
        isOver <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_READY: begin
            if (tick) begin
              if (!isReverse(dirT'(dir), curDir)) curDir <= dirT'(dir);
              state <= S_MOVE;
              busy  <= 1'b1;
            end
          end
          S_MOVE: begin
            nextHead <= stepHead(head, curDir, coordT'(STEP));
            segIdx   <= '0;
            state    <= S_CHECK;
          end
          S_CHECK: begin
            if (hit) begin
              state  <= S_OVER;
              isOver <= 1'b1;
              busy   <= 1'b0;
            end else if (segIdx == LAST_IDX) begin
              state <= S_COMMIT;
            end else begin
              segIdx <= segIdx + 1'b1;
            end
          end
          S_COMMIT: begin
            body  <= {body[SEG_W*(NSEG-1)-1:0], head};
            head  <= nextHead;
            moved <= 1'b1;
            busy  <= 1'b0;
            state <= S_READY;
          end
          S_OVER: ;
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_sequencer.sv
// Directed self-checking bench for snake_sequencer with default parameters.
// Expected coordinates are hand-computed from the start layout and STEP=16.
module tb_snake_sequencer;

  localparam int NSEG = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               tick;
  logic [1:0]         dir;
  logic               obEnd;
  logic [19:0]        head;
  logic [20*NSEG-1:0] body;
  logic               busy;
  logic               moved;
  logic               isOver;

  int checks   = 0;
  int failures = 0;

  snake_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tick  (tick),
    .dir   (dir),
    .obEnd (obEnd),
    .head  (head),
    .body  (body),
    .busy  (busy),
    .moved (moved),
    .isOver(isOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] xy(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  function automatic logic [19:0] segOf(input int k);
    return body[k*20 +: 20];
  endfunction

  // Drive a one-cycle start pulse; returns at the negedge after it was sampled.
  task automatic applyStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Tick in cycle 0, then count cycles until moved or isOver (bounded).
  task automatic runMove(input logic [1:0] d, output int lat, output logic gotMoved,
                         output logic gotOver, output logic busyFirst);
    @(negedge clk);
    tick = 1'b1;
    dir  = d;
    @(negedge clk);
    tick      = 1'b0;
    lat       = 1;
    busyFirst = busy;
    gotMoved  = 1'b0;
    gotOver   = 1'b0;
    while (lat < 40) begin
      if (moved) begin gotMoved = 1'b1; break; end
      if (isOver) begin gotOver = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int   sawActivity;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({head, body, busy, moved, isOver} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got head=%h busy=%b moved=%b isOver=%b want all zero",
               head, busy, moved, isOver);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd1;
    @(negedge clk);
    tick = 1'b0;
    sawActivity = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || moved) sawActivity++;
    end
    checks++;
    if (sawActivity !== 0 || head !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_tick_ignored got activity=%0d head=%h want 0 and 00000",
               sawActivity, head);
    end
  endtask

  task automatic test_first_move();
    int lat; logic gm, go, bf;
    applyStart();
    checks++;
    if (head !== xy(304, 224) || segOf(4) !== xy(224, 224) || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_layout got head=%h seg4=%h busy=%b want %h %h 0",
               head, segOf(4), busy, xy(304, 224), xy(224, 224));
    end
    runMove(2'd1, lat, gm, go, bf);
    checks++;
    if (bf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL move_busy got %b want 1", bf);
    end
    checks++;
    if (lat !== 7 || gm !== 1'b1) begin
      failures++;
      $display("[TB] FAIL move_latency got lat=%0d moved=%b want 7 1", lat, gm);
    end
    checks++;
    if (head !== xy(320, 224) || segOf(0) !== xy(304, 224) || segOf(4) !== xy(240, 224)) begin
      failures++;
      $display("[TB] FAIL move_position got head=%h seg0=%h seg4=%h want %h %h %h",
               head, segOf(0), segOf(4), xy(320, 224), xy(304, 224), xy(240, 224));
    end
    @(negedge clk);
    checks++;
    if (moved !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL moved_pulse got moved=%b busy=%b want 0 0", moved, busy);
    end
  endtask

  task automatic test_reverse_ignored();
    int lat; logic gm, go, bf;
    applyStart();
    runMove(2'd3, lat, gm, go, bf);
    checks++;
    if (gm !== 1'b1 || head !== xy(320, 224)) begin
      failures++;
      $display("[TB] FAIL reverse_ignored got moved=%b head=%h want 1 %h", gm, head, xy(320, 224));
    end
  endtask

  task automatic test_self_hit();
    int lat; logic gm, go, bf;
    int stray;
    applyStart();
    runMove(2'd2, lat, gm, go, bf);
    runMove(2'd3, lat, gm, go, bf);
    checks++;
    if (head !== xy(288, 240) || segOf(2) !== xy(288, 224)) begin
      failures++;
      $display("[TB] FAIL loop_setup got head=%h seg2=%h want %h %h",
               head, segOf(2), xy(288, 240), xy(288, 224));
    end
    runMove(2'd0, lat, gm, go, bf);
    checks++;
    if (lat !== 5 || go !== 1'b1 || gm !== 1'b0) begin
      failures++;
      $display("[TB] FAIL self_hit got lat=%0d over=%b moved=%b want 5 1 0", lat, go, gm);
    end
    checks++;
    if (head !== xy(288, 240) || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL self_hit_frozen got head=%h busy=%b want %h 0", head, busy, xy(288, 240));
    end
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd2;
    @(negedge clk);
    tick = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (moved || busy || !isOver) stray++;
    end
    checks++;
    if (stray !== 0 || head !== xy(288, 240)) begin
      failures++;
      $display("[TB] FAIL over_tick_ignored got stray=%0d head=%h want 0 %h", stray, head, xy(288, 240));
    end
  endtask

  task automatic test_wall();
    int lat; logic gm, go, bf;
    int badMoves;
    applyStart();
    runMove(2'd0, lat, gm, go, bf);
    badMoves = 0;
    for (int i = 0; i < 18; i++) begin
      runMove(2'd3, lat, gm, go, bf);
      if (lat != 7 || !gm) badMoves++;
    end
    checks++;
    if (badMoves !== 0 || head !== xy(16, 208)) begin
      failures++;
      $display("[TB] FAIL wall_approach got bad=%0d head=%h want 0 %h", badMoves, head, xy(16, 208));
    end
    runMove(2'd3, lat, gm, go, bf);
    checks++;
    if (lat !== 3 || go !== 1'b1 || gm !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wall_hit got lat=%0d over=%b moved=%b want 3 1 0", lat, go, gm);
    end
    checks++;
    if (head !== xy(16, 208)) begin
      failures++;
      $display("[TB] FAIL wall_head_frozen got %h want %h", head, xy(16, 208));
    end
  endtask

  task automatic test_obstacle();
    int lat; logic gm, go, bf;
    applyStart();
    obEnd = 1'b1;
    runMove(2'd1, lat, gm, go, bf);
    obEnd = 1'b0;
    checks++;
    if (lat !== 3 || go !== 1'b1 || head !== xy(304, 224)) begin
      failures++;
      $display("[TB] FAIL obstacle_hit got lat=%0d over=%b head=%h want 3 1 %h",
               lat, go, head, xy(304, 224));
    end
    applyStart();
    checks++;
    if (isOver !== 1'b0 || busy !== 1'b0 || head !== xy(304, 224) || segOf(0) !== xy(288, 224)) begin
      failures++;
      $display("[TB] FAIL restart_after_over got isOver=%b busy=%b head=%h seg0=%h want 0 0 %h %h",
               isOver, busy, head, segOf(0), xy(304, 224), xy(288, 224));
    end
  endtask

  task automatic test_start_abort();
    int stray;
    applyStart();
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd2;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || head !== xy(304, 224) || segOf(4) !== xy(224, 224)) begin
      failures++;
      $display("[TB] FAIL start_abort got busy=%b head=%h seg4=%h want 0 %h %h",
               busy, head, segOf(4), xy(304, 224), xy(224, 224));
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (moved || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("[TB] FAIL start_abort_quiet got stray=%0d want 0", stray);
    end
  endtask

  task automatic test_reset_mid_check();
    int stray;
    applyStart();
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({head, body, busy, moved, isOver} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_check got head=%h busy=%b want all zero", head, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (moved || busy || isOver) stray++;
    end
    checks++;
    if (stray !== 0 || head !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_check_idle got stray=%0d head=%h want 0 00000", stray, head);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
    dir   = 2'd0;
    obEnd = 1'b0;
    test_reset();
    test_first_move();
    test_reverse_ignored();
    test_self_hit();
    test_wall();
    test_obstacle();
    test_start_abort();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
